tcm_fetch_buffer: RTL
=====================

// Module: tcm_fetch_buffer
// PURPOSE
//  Instruction-fetch front end sitting directly downstream of the TCM instruction port.
//  Generates 64-bit-aligned fetch requests and absorbs the fixed 1-cycle TCM read latency.
//  Buffers the returned 64-bit pairs in a small FIFO, tagged with PC and half-valid mask.
//  Handles redirects (branch/exception) by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//  DEPTH     4        FIFO entries (power of 2, >=2); also the cap on outstanding + buffered.
//  RESET_PC  32'h0    PC fetched first after reset (bits [2:0] honoured via half mask).
// PORTS
//  clk_i               in   1   clock
//  rst_i               in   1   synchronous reset, active-low
//  mem_i_rd_o          out  1   fetch request to TCM
//  mem_i_pc_o          out  32  fetch address, bits [2:0] always 0
//  mem_i_flush_o       out  1   always 0
//  mem_i_invalidate_o  out  1   registered copy of fetch_invalidate_i
//  mem_i_accept_i      in   1   TCM accepts request this cycle
//  mem_i_valid_i       in   1   response valid
//  mem_i_error_i       in   1   response error
//  mem_i_inst_i        in   64  response data {instr@pc+4, instr@pc}
//  fetch_valid_o       out  1   FIFO head valid
//  fetch_instr_o       out  64  head data
//  fetch_pc_o          out  32  head PC, 8-byte aligned
//  fetch_mask_o        out  2   head half-valid: [0]=low word, [1]=high word
//  fetch_fault_o       out  1   head carries fetch error
//  fetch_accept_i      in   1   decode pops head (effective only when fetch_valid_o)
//  branch_request_i    in   1   redirect
//  branch_pc_i         in   32  redirect target (bit[1:0] ignored)
//  fetch_invalidate_i  in   1   fence.i request, forwarded
// BEHAVIOUR
//  Reset (rst_i==0 at posedge): FIFO empty, outstanding=0, discard=0, pc_q=RESET_PC&~7,
//   first_q mask from RESET_PC[2], stall_q=0; all outputs 0 except mem_i_pc_o=RESET_PC&~7.
//   Reset mid-operation drops everything; responses arriving the cycle after reset deassert are
//   ignored (discard=0, outstanding=0 -> stray mem_i_valid_i must not write FIFO).
//  Issue: mem_i_rd_o = !branch_request_i && !stall_q && (count+outstanding < DEPTH). Combinational.
//   Request completes when mem_i_rd_o && mem_i_accept_i: pc_q += 8 (wraps modulo 2^32),
//   outstanding++, first_q cleared.
//  Response: mem_i_valid_i with discard>0 -> discard--, outstanding--, data dropped.
//   Otherwise push {inst, pc, mask, error}; outstanding--. mask=2'b10 for first fetch after
//   reset/redirect when target[2]=1, else 2'b11. PC of entry is pc of the issuing request
//   (keep a DEPTH-deep PC tag queue or equivalent counter; ordering is strictly in-order).
//  Credit rule guarantees push never hits a full FIFO; push to full is an assertion failure.
//  Error: error entry pushed with fetch_fault_o=1; stall_q set -> no further issue until redirect.
//  Pop: fetch_accept_i && fetch_valid_o removes head; push and pop same cycle -> count unchanged.
//   Push into empty FIFO: fetch_valid_o high next cycle (1 cycle TCM + 0 cycle FIFO bypass not
//   allowed; head is registered). Request-to-fetch_valid_o latency = 2 cycles.
//  Redirect (branch_request_i=1): next cycle FIFO empty, pc_q=branch_pc_i&~7, first_q mask
//   from branch_pc_i[2], stall_q=0, discard = outstanding after this cycle's issue/response
//   accounting (response arriving this same cycle is dropped). No issue in redirect cycle;
//   new-target request issues the following cycle. Redirect beats simultaneous pop.
//   Back-to-back redirects: last one wins; discard accumulates correctly.
//  mem_i_invalidate_o: 1-cycle registered pulse per fetch_invalidate_i cycle.
//  Counters: count and outstanding are clog2(DEPTH)+1 bits; count+outstanding <= DEPTH always.
// TESTING
//  Reset RESET_PC=0, accept=1, decode accepts always -> pcs 0,8,16,24 on fetch_pc_o, mask 11.
//  fetch_accept_i=0 for 10 cycles -> exactly DEPTH=4 requests issued, then mem_i_rd_o=0; resume.
//  Redirect to 32'h104 with 1 in flight -> in-flight data dropped; next head pc 0x100 mask 10.
//  mem_i_error_i on pc 0x18 -> head fault=1 at 0x18, no requests until branch to 0x40 resumes.
//  mem_i_accept_i toggling 1,0,1,0 -> pc advances only on accepted cycles; no gaps or duplicates.
//  PC 32'hFFFFFFF8 -> next request 32'h0; rst_i low mid-burst -> FIFO empty, pc=RESET_PC.

Source files
------------

// File: rtl/tcm_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tcm_fetch_buffer
// Instruction-fetch front end for the TCM instruction port. Issues 8-byte
// aligned fetch requests, absorbs the fixed 1-cycle TCM read latency and
// buffers returned 64-bit pairs in a DEPTH-entry FIFO tagged with PC, a
// half-valid mask and a fault flag. Redirects flush the FIFO and drop any
// responses still in flight.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-low reset
//   mem_i_rd_o / mem_i_pc_o    fetch request and aligned address
//   mem_i_flush_o              tied low
//   mem_i_invalidate_o         registered copy of fetch_invalidate_i
//   mem_i_accept_i             TCM takes the request this cycle
//   mem_i_valid_i/error_i/inst_i  TCM response
//   fetch_valid_o .. fault_o   FIFO head towards decode
//   fetch_accept_i             decode pops the head
//   branch_request_i/pc_i      redirect
//   fetch_invalidate_i         fence.i request
// ---------------------------------------------------------------------------
module tcm_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_i_rd_o,
   output logic [31:0] mem_i_pc_o,
   output logic        mem_i_flush_o,
   output logic        mem_i_invalidate_o,
   input  logic        mem_i_accept_i,
   input  logic        mem_i_valid_i,
   input  logic        mem_i_error_i,
   input  logic [63:0] mem_i_inst_i,
   output logic        fetch_valid_o,
   output logic [63:0] fetch_instr_o,
   output logic [31:0] fetch_pc_o,
   output logic [1:0]  fetch_mask_o,
   output logic        fetch_fault_o,
   input  logic        fetch_accept_i,
   input  logic        branch_request_i,
   input  logic [31:0] branch_pc_i,
   input  logic        fetch_invalidate_i
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   // FIFO storage
   logic [63:0]   r_inst [DEPTH];
   logic [31:0]   r_pc_tag [DEPTH];
   logic [1:0]    r_mask [DEPTH];
   logic          r_err [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // Request / response tracking
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [31:0]   r_pc;        // next request address
   logic [31:0]   r_resp_pc;   // PC of the next response that will be kept
   logic [1:0]    r_resp_mask; // half mask of the next kept response
   logic          r_stall;
   logic          r_inv;

   logic [CW:0]   w_inflight;
   logic          w_credit;
   logic          w_issue;
   logic          w_resp;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_out_next;
   logic [31:0]   w_branch_pc;
   logic          w_unused;

   assign w_inflight  = (CW+1)'(r_count) + (CW+1)'(r_outstanding);
   assign w_credit    = w_inflight < (CW+1)'(DEPTH);
   assign w_branch_pc = {branch_pc_i[31:3], 3'b000};
   assign w_unused    = &{1'b0, branch_pc_i[1:0]};

   assign mem_i_rd_o = !branch_request_i && !r_stall && w_credit;
   assign w_issue    = mem_i_rd_o && mem_i_accept_i;

   // A response with nothing outstanding is stray (e.g. straddling reset) and ignored.
   assign w_resp     = mem_i_valid_i && (r_outstanding != '0);
   assign w_push     = w_resp && (r_discard == '0) && !branch_request_i;
   assign w_pop      = fetch_accept_i && fetch_valid_o && !branch_request_i;
   assign w_out_next = r_outstanding + CW'(w_issue) - CW'(w_resp);

   // State update; a redirect overrides any push/pop in the same cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_inst[i]   <= '0;
            r_pc_tag[i] <= '0;
            r_mask[i]   <= '0;
            r_err[i]    <= 1'b0;
         end
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_pc          <= {RESET_PC[31:3], 3'b000};
         r_resp_pc     <= {RESET_PC[31:3], 3'b000};
         r_resp_mask   <= RESET_PC[2] ? 2'b10 : 2'b11;
         r_stall       <= 1'b0;
         r_inv         <= 1'b0;
      end else begin
         r_inv         <= fetch_invalidate_i;
         r_outstanding <= w_out_next;
         if (branch_request_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pc        <= w_branch_pc;
            r_resp_pc   <= w_branch_pc;
            r_resp_mask <= branch_pc_i[2] ? 2'b10 : 2'b11;
            r_stall     <= 1'b0;
            // Everything still in flight after this cycle belongs to the old path.
            r_discard   <= w_out_next;
         end else begin
            if (w_issue) begin
               r_pc <= r_pc + 32'd8;
            end
            if (w_resp && (r_discard != '0)) begin
               r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
               r_inst[r_wr_ptr]   <= mem_i_inst_i;
               r_pc_tag[r_wr_ptr] <= r_resp_pc;
               r_mask[r_wr_ptr]   <= r_resp_mask;
               r_err[r_wr_ptr]    <= mem_i_error_i;
               r_wr_ptr           <= r_wr_ptr + PW'(1);
               r_resp_pc          <= r_resp_pc + 32'd8;
               r_resp_mask        <= 2'b11;
               if (mem_i_error_i) begin
                  r_stall <= 1'b1;
               end
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // Credit accounting must never let a push land on a full FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i && w_push) begin
         assert (r_count != CW'(DEPTH));
      end
   end

   assign mem_i_pc_o         = r_pc;
   assign mem_i_flush_o      = 1'b0;
   assign mem_i_invalidate_o = r_inv;
   assign fetch_valid_o      = (r_count != '0);
   assign fetch_instr_o      = r_inst[r_rd_ptr];
   assign fetch_pc_o         = r_pc_tag[r_rd_ptr];
   assign fetch_mask_o       = r_mask[r_rd_ptr];
   assign fetch_fault_o      = r_err[r_rd_ptr];

endmodule
